// File: rtl/mips_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg
// Shared constants for the 5-stage MIPS pipeline control blocks.
//   REG_W      : register address width (32 architectural registers)
//   FWD_*      : EX-stage operand forward select encodings
//   REG_ZERO   : register number of the hard-wired zero register
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX/MEM pipe register
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from MEM/WB pipe register

    localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage : mips_pipe_pkg

// File: rtl/fwd_src_sel.sv
// ---------------------------------------------------------------------------
// fwd_src_sel
// Forward select for a single EX-stage source operand. The MEM-stage result
// is younger than the WB-stage result, so it takes priority. r0 is never
// forwarded because writes to it are discarded.
// Ports:
//   exeSrc  in  EX-stage source register number
//   memRd   in  MEM-stage destination register
//   memWb   in  MEM-stage instruction writes back
//   wbRd    in  WB-stage destination register
//   wb      in  WB-stage instruction writes back
//   sel     out forward select (FWD_REG / FWD_MEM / FWD_WB)
// ---------------------------------------------------------------------------
module fwd_src_sel
    import mips_pipe_pkg::*;
#(
    parameter int AddrW = REG_W
) (
    input  logic [AddrW-1:0] exeSrc,
    input  logic [AddrW-1:0] memRd,
    input  logic             memWb,
    input  logic [AddrW-1:0] wbRd,
    input  logic             wb,
    output logic [1:0]       sel
);

    localparam logic [AddrW-1:0] RegZero = AddrW'(REG_ZERO);

    always_comb begin
        // NOTE: default assigned first so every path drives sel; no latch.
        sel = FWD_REG;
        if (memWb && (memRd != RegZero) && (memRd == exeSrc)) begin
            sel = FWD_MEM;
        end else if (wb && (wbRd != RegZero) && (wbRd == exeSrc)) begin
            sel = FWD_WB;
        end
    end

endmodule : fwd_src_sel

// File: rtl/fwd_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_hazard_scoreboard
// Forwarding and hazard unit for the 5-stage pipeline with a multi-cycle,
// unpipelined multiplier. Produces EX forward selects, tracks the
// multiplier's in-flight destination in a per-register pending scoreboard,
// and raises the ID-stage stall for load-use, RAW-on-pending, WAW-on-pending
// and multiplier-busy hazards.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-low reset
//   IdSrc/IdSrcUsed   ID source registers (src0 in LSBs) and read flags
//   IdRd/IdWb/IdIsMul ID destination, writes-back flag, is-multiply flag
//   ExeSrc/ExeRd      EX source registers and destination
//   ExeMemRead        EX instruction is a load
//   ExeMulIssue       EX instruction is a multiply launched this cycle
//   MemRd/MemWb       MEM destination and write-back flag
//   WbRd/Wb           WB destination and write-back flag
//   forward_sel       per-source EX forward select, 2 bits each
//   IdMulBypass       per-source: ID takes the multiplier result this cycle
//   Stall             hold PC and IF/ID, bubble ID/EX
//   MulDone/MulDoneRd multiplier result valid and its destination
//   MulBusy           multiplier occupied
//   StallCnt          saturating count of stall cycles
// ---------------------------------------------------------------------------
module fwd_hazard_scoreboard
    import mips_pipe_pkg::*;
#(
    parameter int REG_W   = mips_pipe_pkg::REG_W,
    parameter int NUM_SRC = 2,
    parameter int MUL_LAT = 4,   // must be >= 2
    parameter int CNT_W   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_SRC*REG_W-1:0] IdSrc,
    input  logic [NUM_SRC-1:0]       IdSrcUsed,
    input  logic [REG_W-1:0]         IdRd,
    input  logic                     IdWb,
    input  logic                     IdIsMul,
    input  logic [NUM_SRC*REG_W-1:0] ExeSrc,
    input  logic [REG_W-1:0]         ExeRd,
    input  logic                     ExeMemRead,
    input  logic                     ExeMulIssue,
    input  logic [REG_W-1:0]         MemRd,
    input  logic                     MemWb,
    input  logic [REG_W-1:0]         WbRd,
    input  logic                     Wb,
    output logic [NUM_SRC*2-1:0]     forward_sel,
    output logic [NUM_SRC-1:0]       IdMulBypass,
    output logic                     Stall,
    output logic                     MulDone,
    output logic [REG_W-1:0]         MulDoneRd,
    output logic                     MulBusy,
    output logic [CNT_W-1:0]         StallCnt
);

    localparam int                   NumRegs = 1 << REG_W;
    localparam int                   CntBits = $clog2(MUL_LAT);
    localparam logic [CntBits-1:0]   CntLoad = CntBits'(MUL_LAT - 1);
    localparam logic [REG_W-1:0]     RegZero = REG_W'(REG_ZERO);

    logic [NumRegs-1:0] pending;
    logic [NumRegs-1:0] pendingNext;
    logic [CntBits-1:0] mulCnt;
    logic               mulBusyQ;
    logic [REG_W-1:0]   mulRdQ;
    logic               issueAcc;
    logic [NUM_SRC-1:0] srcStall;
    logic               wawStall;
    logic               structStall;

    // Result appears when the countdown reaches zero, MUL_LAT cycles after issue.
    assign MulDone   = mulBusyQ && (mulCnt == '0);
    assign MulDoneRd = mulRdQ;
    assign MulBusy   = mulBusyQ;

    // A new multiply is accepted when idle or in the completing cycle; an
    // issue while still counting is impossible given the structural stall
    // and is dropped.
    assign issueAcc = ExeMulIssue && (!mulBusyQ || MulDone);

    // Clear first, then set: a back-to-back multiply to the same register
    // keeps the pending bit.
    always_comb begin
        pendingNext = pending;
        if (MulDone) begin
            pendingNext[mulRdQ] = 1'b0;
        end
        if (issueAcc && (ExeRd != RegZero)) begin
            pendingNext[ExeRd] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: pending is a flop vector, not a RAM, so it is reset
            // with the rest of the state; a mid-multiply reset abandons it.
            pending  <= '0;
            mulCnt   <= '0;
            mulBusyQ <= 1'b0;
            mulRdQ   <= '0;
            StallCnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            pending <= pendingNext;
            if (issueAcc) begin
                mulBusyQ <= 1'b1;
                mulCnt   <= CntLoad;
                mulRdQ   <= ExeRd;
            end else if (MulDone) begin
                mulBusyQ <= 1'b0;
            end else if (mulBusyQ) begin
                mulCnt <= mulCnt - 1'b1;
            end
            if (Stall && (StallCnt != '1)) begin
                StallCnt <= StallCnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
        logic [REG_W-1:0] idSrc;
        logic             srcLive;
        logic             doneHit;
        logic             loadUse;
        logic             issueRaw;
        logic             pendRaw;

        assign idSrc    = IdSrc[i*REG_W +: REG_W];
        assign srcLive  = IdSrcUsed[i] && (idSrc != RegZero);
        assign doneHit  = MulDone && (mulRdQ == idSrc);
        assign loadUse  = ExeMemRead && (ExeRd == idSrc);
        assign issueRaw = ExeMulIssue && (ExeRd == idSrc);
        // Completing result is bypassed into ID, so its pending bit no
        // longer blocks this source.
        assign pendRaw  = pending[idSrc] && !doneHit;

        assign srcStall[i]    = srcLive && (loadUse || issueRaw || pendRaw);
        assign IdMulBypass[i] = IdSrcUsed[i] && doneHit && (mulRdQ != RegZero);

        fwd_src_sel #(
            .AddrW (REG_W)
        ) uFwdSel (
            .exeSrc (ExeSrc[i*REG_W +: REG_W]),
            .memRd  (MemRd),
            .memWb  (MemWb),
            .wbRd   (WbRd),
            .wb     (Wb),
            .sel    (forward_sel[2*i +: 2])
        );
    end

    // Writing a register the multiplier will write later would be undone by
    // the late multiply result, unless that result lands this very cycle.
    assign wawStall = IdWb && (IdRd != RegZero)
                      && (pending[IdRd] || (ExeMulIssue && (ExeRd == IdRd)))
                      && !(MulDone && (mulRdQ == IdRd));

    assign structStall = IdIsMul && mulBusyQ && !MulDone;

    assign Stall = (|srcStall) || wawStall || structStall;

endmodule : fwd_hazard_scoreboard

// File: tb/tb_fwd_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_scoreboard
// Directed bench for fwd_hazard_scoreboard (REG_W=5, NUM_SRC=2, MUL_LAT=4).
// The stall counter is narrowed to 4 bits so saturation is reachable.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_scoreboard;

    localparam int RW = 5;
    localparam int NS = 2;
    localparam int CW = 4;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [NS*RW-1:0] IdSrc;
    logic [NS-1:0]  IdSrcUsed;
    logic [RW-1:0]  IdRd;
    logic           IdWb;
    logic           IdIsMul;
    logic [NS*RW-1:0] ExeSrc;
    logic [RW-1:0]  ExeRd;
    logic           ExeMemRead;
    logic           ExeMulIssue;
    logic [RW-1:0]  MemRd;
    logic           MemWb;
    logic [RW-1:0]  WbRd;
    logic           Wb;
    logic [NS*2-1:0] forward_sel;
    logic [NS-1:0]  IdMulBypass;
    logic           Stall;
    logic           MulDone;
    logic [RW-1:0]  MulDoneRd;
    logic           MulBusy;
    logic [CW-1:0]  StallCnt;

    int compared   = 0;
    int mismatched = 0;
    int doneSeen;

    always #5 clk_i = ~clk_i;

    fwd_hazard_scoreboard #(
        .REG_W   (RW),
        .NUM_SRC (NS),
        .MUL_LAT (4),
        .CNT_W   (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .IdSrc       (IdSrc),
        .IdSrcUsed   (IdSrcUsed),
        .IdRd        (IdRd),
        .IdWb        (IdWb),
        .IdIsMul     (IdIsMul),
        .ExeSrc      (ExeSrc),
        .ExeRd       (ExeRd),
        .ExeMemRead  (ExeMemRead),
        .ExeMulIssue (ExeMulIssue),
        .MemRd       (MemRd),
        .MemWb       (MemWb),
        .WbRd        (WbRd),
        .Wb          (Wb),
        .forward_sel (forward_sel),
        .IdMulBypass (IdMulBypass),
        .Stall       (Stall),
        .MulDone     (MulDone),
        .MulDoneRd   (MulDoneRd),
        .MulBusy     (MulBusy),
        .StallCnt    (StallCnt)
    );

    // A multiply must never reach EX while the multiplier is still counting.
    always @(negedge clk_i) begin
        if (rst_i === 1'b1) begin
            assert (!(ExeMulIssue && MulBusy && !MulDone))
                else $error("multiply issued while multiplier busy");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        IdSrc       = '0;
        IdSrcUsed   = '0;
        IdRd        = '0;
        IdWb        = 1'b0;
        IdIsMul     = 1'b0;
        ExeSrc      = '0;
        ExeRd       = '0;
        ExeMemRead  = 1'b0;
        ExeMulIssue = 1'b0;
        MemRd       = '0;
        MemWb       = 1'b0;
        WbRd        = '0;
        Wb          = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    initial begin
        idle();
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        sample();
        check("rst_busy",   32'(MulBusy),     32'd0);
        check("rst_done",   32'(MulDone),     32'd0);
        check("rst_doneRd", 32'(MulDoneRd),   32'd0);
        check("rst_cnt",    32'(StallCnt),    32'd0);
        check("rst_stall",  32'(Stall),       32'd0);
        check("rst_fwd",    32'(forward_sel), 32'd0);

        // ---------------- forwarding priority ----------------
        nextCycle();
        ExeSrc = {5'd0, 5'd5}; MemRd = 5'd5; WbRd = 5'd5; MemWb = 1'b1; Wb = 1'b1;
        sample();
        check("fwd_mem_prio", 32'(forward_sel), 32'b0010);
        nextCycle();
        MemWb = 1'b0;
        sample();
        check("fwd_wb", 32'(forward_sel), 32'b0001);
        nextCycle();
        ExeSrc = {5'd7, 5'd0}; MemRd = 5'd0; WbRd = 5'd0; MemWb = 1'b1; Wb = 1'b1;
        sample();
        check("fwd_r0", 32'(forward_sel), 32'b0000);
        nextCycle();
        ExeSrc = {5'd7, 5'd3}; MemRd = 5'd3; WbRd = 5'd7;
        sample();
        check("fwd_both_src", 32'(forward_sel), 32'b0110);

        // ---------------- load-use ----------------
        nextCycle();
        idle();
        ExeMemRead = 1'b1; ExeRd = 5'd8; IdSrc = {5'd8, 5'd0}; IdSrcUsed = 2'b10;
        sample();
        check("lu_stall", 32'(Stall), 32'd1);
        nextCycle();
        idle();
        sample();
        check("lu_release", 32'(Stall),    32'd0);
        check("lu_cnt",     32'(StallCnt), 32'd1);
        nextCycle();
        ExeMemRead = 1'b1; ExeRd = 5'd8; IdSrc = {5'd8, 5'd0}; IdSrcUsed = 2'b01;
        sample();
        check("lu_unused", 32'(Stall), 32'd0);
        nextCycle();
        ExeMemRead = 1'b1; ExeRd = 5'd0; IdSrc = {5'd0, 5'd0}; IdSrcUsed = 2'b11;
        sample();
        check("lu_r0", 32'(Stall), 32'd0);

        // ---------------- multiply latency, RAW on r9 ----------------
        nextCycle();
        idle();
        ExeMulIssue = 1'b1; ExeRd = 5'd9; IdSrc = {5'd0, 5'd9}; IdSrcUsed = 2'b01;
        sample();
        check("mul_c0_stall", 32'(Stall),   32'd1);
        check("mul_c0_busy",  32'(MulBusy), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            nextCycle();
            ExeMulIssue = 1'b0; ExeRd = 5'd0;
            sample();
            check($sformatf("mul_c%0d_stall", c), 32'(Stall),   32'd1);
            check($sformatf("mul_c%0d_done", c),  32'(MulDone), 32'd0);
            check($sformatf("mul_c%0d_busy", c),  32'(MulBusy), 32'd1);
        end
        nextCycle();
        sample();
        check("mul_c4_done",   32'(MulDone),     32'd1);
        check("mul_c4_rd",     32'(MulDoneRd),   32'd9);
        check("mul_c4_stall",  32'(Stall),       32'd0);
        check("mul_c4_bypass", 32'(IdMulBypass), 32'b01);
        nextCycle();
        sample();
        check("mul_c5_stall", 32'(Stall),    32'd0);
        check("mul_c5_busy",  32'(MulBusy),  32'd0);
        check("mul_c5_done",  32'(MulDone),  32'd0);
        check("mul_c5_cnt",   32'(StallCnt), 32'd5);

        // ---------------- structural, back-to-back, WAW ----------------
        nextCycle();
        idle();
        ExeMulIssue = 1'b1; ExeRd = 5'd9;
        sample();
        check("b2b_c0_stall", 32'(Stall), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            nextCycle();
            idle();
            IdIsMul = 1'b1;
            sample();
            check($sformatf("struct_c%0d_stall", c), 32'(Stall), 32'd1);
        end
        nextCycle();
        IdIsMul = 1'b1; ExeMulIssue = 1'b1; ExeRd = 5'd9;
        sample();
        check("b2b_c4_done",  32'(MulDone), 32'd1);
        check("b2b_c4_stall", 32'(Stall),   32'd0);
        for (int c = 5; c <= 7; c++) begin
            nextCycle();
            idle();
            IdWb = 1'b1; IdRd = 5'd9;
            sample();
            check($sformatf("waw_c%0d_stall", c), 32'(Stall),   32'd1);
            check($sformatf("waw_c%0d_busy", c),  32'(MulBusy), 32'd1);
            check($sformatf("waw_c%0d_done", c),  32'(MulDone), 32'd0);
        end
        nextCycle();
        sample();
        check("b2b_c8_done",  32'(MulDone),   32'd1);
        check("b2b_c8_rd",    32'(MulDoneRd), 32'd9);
        check("b2b_c8_stall", 32'(Stall),     32'd0);
        nextCycle();
        sample();
        check("b2b_c9_busy",  32'(MulBusy),  32'd0);
        check("b2b_c9_stall", 32'(Stall),    32'd0);
        check("b2b_c9_cnt",   32'(StallCnt), 32'd11);

        // ---------------- multiply to r0 ----------------
        nextCycle();
        idle();
        ExeMulIssue = 1'b1; ExeRd = 5'd0; IdSrc = {5'd0, 5'd0}; IdSrcUsed = 2'b11;
        IdWb = 1'b1; IdRd = 5'd0;
        sample();
        check("r0_c0_stall", 32'(Stall), 32'd0);
        repeat (3) begin
            nextCycle();
            ExeMulIssue = 1'b0;
        end
        nextCycle();
        sample();
        check("r0_c4_done",   32'(MulDone),     32'd1);
        check("r0_c4_rd",     32'(MulDoneRd),   32'd0);
        check("r0_c4_bypass", 32'(IdMulBypass), 32'b00);
        check("r0_c4_stall",  32'(Stall),       32'd0);

        // ---------------- stall counter saturation (4-bit) ----------------
        repeat (5) begin
            nextCycle();
            idle();
            ExeMemRead = 1'b1; ExeRd = 5'd4; IdSrc = {5'd0, 5'd4}; IdSrcUsed = 2'b01;
        end
        nextCycle();
        idle();
        sample();
        check("cnt_saturate", 32'(StallCnt), 32'd15);

        // ---------------- reset in the middle of a multiply ----------------
        nextCycle();
        ExeMulIssue = 1'b1; ExeRd = 5'd9; IdSrc = {5'd0, 5'd9}; IdSrcUsed = 2'b01;
        nextCycle();
        ExeMulIssue = 1'b0; ExeRd = 5'd0;
        nextCycle();
        rst_i = 1'b0;
        #1;
        check("rst_mid_busy",   32'(MulBusy),   32'd0);
        check("rst_mid_cnt",    32'(StallCnt),  32'd0);
        check("rst_mid_stall",  32'(Stall),     32'd0);
        check("rst_mid_doneRd", 32'(MulDoneRd), 32'd0);
        nextCycle();
        rst_i    = 1'b1;
        doneSeen = 0;
        repeat (6) begin
            nextCycle();
            sample();
            if (MulDone !== 1'b0) doneSeen++;
        end
        check("rst_mid_no_done", 32'(doneSeen), 32'd0);
        check("rst_mid_stall2",  32'(Stall),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_fwd_hazard_scoreboard
